shell_ctrl: RTL
===============

SHELL_CTRL -- requirements
Module: shell_ctrl

Interface
REQ-001 Parameter SPEED, default 4: pixels moved per frame_tick while flying.
REQ-002 Parameter BULLET_SIZE, default 4: bullet square edge, pixels.
REQ-003 Parameter TANK_SIZE, default 32: tank square edge, pixels.
REQ-004 Parameter EXPLODE_FRAMES, default 8: frames the explode phase lasts.
REQ-005 Parameter COOLDOWN_FRAMES, default 16: minimum frames between launches.
REQ-006 clk  in  1  single clock, 25 MHz pixel clock; all logic on rising edge.
REQ-007 RSTN  in  1  reset, asynchronous, active-low.
REQ-008 frame_tick  in  1  one-cycle pulse per video frame (vsync start).
REQ-009 shoot  in  1  debounced fire button, level.
REQ-010 tank_x, tank_y  in  10 each  tank top-left pixel.
REQ-011 tank_dir  in  3  0 up, 1 down, 2 left, 3 right, 4-7 invalid.
REQ-012 bullet_x, bullet_y  out  10 each  bullet top-left pixel.
REQ-013 bullet_active  out  1  bullet flying, to be drawn.
REQ-014 explode  out  1  explode phase in progress, at bullet_x/bullet_y.
REQ-015 hit_wall  out  1  one-cycle pulse on field-edge impact.

Function
REQ-016 States IDLE, FLY, EXPLODE; bullet_active high only in FLY, explode high only in EXPLODE.
REQ-017 Launch request = rising edge of shoot (registered prior sample low, current high); held level never re-fires.
REQ-018 IDLE -> FLY on launch request when cooldown counter is 0 and tank_dir is 0-3; otherwise request dropped, not queued.
REQ-019 On launch, latch dir; bullet_x = tank_x + TANK_SIZE/2 - BULLET_SIZE/2, bullet_y likewise, saturated to [0, 640-BULLET_SIZE] and [0, 480-BULLET_SIZE].
REQ-020 On launch, cooldown loads COOLDOWN_FRAMES; decrements by 1 per frame_tick, saturating at 0, in every state.
REQ-021 Launch and frame_tick in same cycle: launch wins; first move on next frame_tick; cooldown decrement not applied that cycle.
REQ-022 FLY, per frame_tick: position advances SPEED in latched dir; arithmetic in 11 bits, no wrap-around.
REQ-023 If the move would cross x<0, y<0, x>640-BULLET_SIZE or y>480-BULLET_SIZE, position clamps to that edge, hit_wall pulses that cycle, next state EXPLODE.
REQ-024 Launch requests in FLY or EXPLODE are ignored; tank_* changes after launch do not affect the bullet.
REQ-025 EXPLODE: frame counter loads EXPLODE_FRAMES on entry, decrements per frame_tick; on reaching 0 -> IDLE; position held.
REQ-026 Outputs registered; state and outputs change one cycle after the causing input edge.

Reset
REQ-027 RSTN low asynchronously forces IDLE, bullet_x=0, bullet_y=0, bullet_active=0, explode=0, hit_wall=0, cooldown=0, explode counter=0, shoot history=0.
REQ-028 Reset asserted mid-flight or mid-explode aborts immediately; after release, a shoot held high does not fire until released and re-pressed.

Structure
REQ-029 Shared package tankwar_pkg holds direction encoding constants, field width 640, field height 480, state enum.
REQ-030 One sub-module rise_pulse (registered rising-edge detector) for shoot; all else in shell_ctrl.

Verification
REQ-031 tank (100,200), dir right, press shoot -> next cycle FLY, bullet (114,214); after 3 frame_ticks bullet_x=126.
REQ-032 dir left from tank (0,100) -> launch at (14,114); 4th tick clamps x=0, hit_wall one cycle, explode high 8 frames, then IDLE.
REQ-033 Hold shoot high across 40 frames -> exactly one launch; re-press at frame 10 after impact -> fires only if 16 frames since launch.
REQ-034 Launch pulse coincident with frame_tick -> bullet at spawn point, first move on following tick.
REQ-035 dir=5 with shoot edge -> stays IDLE, cooldown stays 0.
REQ-036 RSTN pulsed low mid-flight -> all outputs 0 immediately; held shoot after release does not fire.

Source files
------------

// File: rtl/tankwar_pkg.sv
// Shared tank-war definitions: direction encoding, playfield size, shell FSM states
// and the spawn-point helper used when a shell is fired.
package tankwar_pkg;

  localparam logic [2:0] DIR_UP    = 3'd0;
  localparam logic [2:0] DIR_DOWN  = 3'd1;
  localparam logic [2:0] DIR_LEFT  = 3'd2;
  localparam logic [2:0] DIR_RIGHT = 3'd3;

  localparam int unsigned FIELD_W = 640;
  localparam int unsigned FIELD_H = 480;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FLY     = 2'd1,
    ST_EXPLODE = 2'd2
  } shell_state_e;

  function automatic logic dir_valid(input logic [2:0] dir);
    return (dir[2] == 1'b0);
  endfunction

  // Spawn coordinate: tank corner plus centring offset, clipped to the last legal pixel.
  function automatic logic [9:0] spawn_coord(input logic [9:0]  tank,
                                             input logic [10:0] offset,
                                             input logic [10:0] max_pos);
    logic [10:0] sum;
    sum = {1'b0, tank} + offset;
    return (sum > max_pos) ? max_pos[9:0] : sum[9:0];
  endfunction

endpackage

// File: rtl/rise_pulse.sv
// Registered rising-edge detector for the fire button. It stays disarmed after
// reset until a low sample is seen, so a button held through reset never fires.
module rise_pulse (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic pulse_o
);

  logic prev_q;
  logic armed_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q <= d_i;
      if (!d_i) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign pulse_o = d_i & ~prev_q & armed_q;

endmodule

// File: rtl/shell_ctrl.sv
// Tank shell controller: launches a shell on a fire-button press, moves it once per
// frame, detects field-edge impact, times the explosion and enforces a reload cooldown.
module shell_ctrl
  import tankwar_pkg::*;
#(
  parameter int unsigned SPEED           = 4,
  parameter int unsigned BULLET_SIZE     = 4,
  parameter int unsigned TANK_SIZE       = 32,
  parameter int unsigned EXPLODE_FRAMES  = 8,
  parameter int unsigned COOLDOWN_FRAMES = 16
) (
  input  logic       clk,
  input  logic       RSTN,
  input  logic       frame_tick,
  input  logic       shoot,
  input  logic [9:0] tank_x,
  input  logic [9:0] tank_y,
  input  logic [2:0] tank_dir,
  output logic [9:0] bullet_x,
  output logic [9:0] bullet_y,
  output logic       bullet_active,
  output logic       explode,
  output logic       hit_wall
);

  localparam logic [10:0] X_MAX  = 11'(FIELD_W - BULLET_SIZE);
  localparam logic [10:0] Y_MAX  = 11'(FIELD_H - BULLET_SIZE);
  localparam logic [10:0] OFFSET = 11'(TANK_SIZE / 2 - BULLET_SIZE / 2);
  localparam logic [10:0] STEP   = 11'(SPEED);

  shell_state_e state_q, state_d;
  logic [9:0]   x_q, x_d;
  logic [9:0]   y_q, y_d;
  logic [2:0]   dir_q, dir_d;
  logic [15:0]  cool_q, cool_d;
  logic [15:0]  boom_q, boom_d;
  logic         active_q, active_d;
  logic         explode_q, explode_d;
  logic         hit_q, hit_d;
  logic         launch;
  logic [10:0]  x_ext, y_ext;

  rise_pulse u_shoot_edge (
    .clk_i   (clk),
    .rst_ni  (RSTN),
    .d_i     (shoot),
    .pulse_o (launch)
  );

  assign x_ext = {1'b0, x_q};
  assign y_ext = {1'b0, y_q};

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    cool_d  = cool_q;
    boom_d  = boom_q;
    hit_d   = 1'b0;

    if (frame_tick && (cool_q != '0)) begin
      cool_d = cool_q - 16'd1;
    end

    case (state_q)
      ST_IDLE: begin
        // A launch reloads the cooldown, overriding any decrement from a coincident tick.
        if (launch && (cool_q == '0) && dir_valid(tank_dir)) begin
          state_d = ST_FLY;
          dir_d   = tank_dir;
          x_d     = spawn_coord(tank_x, OFFSET, X_MAX);
          y_d     = spawn_coord(tank_y, OFFSET, Y_MAX);
          cool_d  = 16'(COOLDOWN_FRAMES);
        end
      end

      ST_FLY: begin
        if (frame_tick) begin
          case (dir_q)
            DIR_UP: begin
              if (y_ext < STEP) begin
                y_d   = '0;
                hit_d = 1'b1;
              end else begin
                y_d = 10'(y_ext - STEP);
              end
            end
            DIR_DOWN: begin
              if (y_ext + STEP > Y_MAX) begin
                y_d   = Y_MAX[9:0];
                hit_d = 1'b1;
              end else begin
                y_d = 10'(y_ext + STEP);
              end
            end
            DIR_LEFT: begin
              if (x_ext < STEP) begin
                x_d   = '0;
                hit_d = 1'b1;
              end else begin
                x_d = 10'(x_ext - STEP);
              end
            end
            default: begin
              if (x_ext + STEP > X_MAX) begin
                x_d   = X_MAX[9:0];
                hit_d = 1'b1;
              end else begin
                x_d = 10'(x_ext + STEP);
              end
            end
          endcase
          if (hit_d) begin
            state_d = ST_EXPLODE;
            boom_d  = 16'(EXPLODE_FRAMES);
          end
        end
      end

      ST_EXPLODE: begin
        if (frame_tick) begin
          if (boom_q <= 16'd1) begin
            boom_d  = '0;
            state_d = ST_IDLE;
          end else begin
            boom_d = boom_q - 16'd1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    active_d  = (state_d == ST_FLY);
    explode_d = (state_d == ST_EXPLODE);
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      dir_q     <= '0;
      cool_q    <= '0;
      boom_q    <= '0;
      active_q  <= 1'b0;
      explode_q <= 1'b0;
      hit_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dir_q     <= dir_d;
      cool_q    <= cool_d;
      boom_q    <= boom_d;
      active_q  <= active_d;
      explode_q <= explode_d;
      hit_q     <= hit_d;
    end
  end

  assign bullet_x      = x_q;
  assign bullet_y      = y_q;
  assign bullet_active = active_q;
  assign explode       = explode_q;
  assign hit_wall      = hit_q;

endmodule
